keypad_hex_entry: RTL and testbench

- Scans a 4x4 hex keypad and debounces each press into one key event.
- Shifts each accepted hex digit into a 32-bit entry word.
- The input-side counterpart of the board's multiplexed 7-segment driver: the display scans anodes to output digits, this block scans rows to input them.
- `data` feeds the 7-segment driver and the CPU's switch/IO read port.

---
 rtl/keypad_pkg.sv | 26 ++
 rtl/sync2.sv | 33 +++
 rtl/keypad_hex_entry.sv | 158 +++++++++++++++
 tb/tb_keypad_hex_entry.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, key map and row encoding for the hex keypad scanner
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN = 2'd0,
        ST_PDEB = 2'd1,
        ST_HELD = 2'd2,
        ST_RDEB = 2'd3
    } state_t;

    // Nibble i holds the hex value of the key at {row, col} = i.
    // Rows from r0: "1 2 3 A", "4 5 6 B", "7 8 9 C", "0 F E D".
    localparam logic [63:0] KEY_MAP = 64'hDEF0_C987_B654_A321;

    function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
        logic [5:0] base;
        base = {r, c, 2'b00};
        return KEY_MAP[base +: 4];
    endfunction

    // One-hot-low pattern: only bit idx driven low.
    function automatic logic [3:0] onehot_low(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer, resets to all-ones (idle keypad columns)
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    // Next-state: plain two-stage shift.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer flops; idle level is all-ones because columns are pulled up.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_hex_entry.sv
// rtl/keypad_hex_entry.sv - 4x4 keypad scanner with debounce, shifts hex digits into a 32-bit word
module keypad_hex_entry #(
    parameter int SCAN_BITS       = 17,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        flush,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    output logic [31:0] data,
    output logic [3:0]  key_code,
    output logic        key_valid
);

    import keypad_pkg::*;

    localparam int DEB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DEB_W-1:0]     DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SCAN_BITS-1:0] DWELL_LAST = '1;

    logic [3:0] cs;

    state_t                state_q, state_d;
    logic [1:0]            row_idx_q, row_idx_d;
    logic [1:0]            col_idx_q, col_idx_d;
    logic [SCAN_BITS-1:0]  dwell_q, dwell_d;
    logic [DEB_W-1:0]      deb_q, deb_d;
    logic [31:0]           data_q, data_d;
    logic [3:0]            key_code_q, key_code_d;
    logic                  key_valid_q, key_valid_d;

    logic                  one_low;
    logic [1:0]            c_idx;
    logic                  accept;
    logic [3:0]            map_code;

    sync2 #(.WIDTH(4)) u_col_sync (
        .clk (clk),
        .clr (clr),
        .d   (col),
        .q   (cs)
    );

    // Decode the synchronized columns: valid only when exactly one is pulled low.
    always_comb begin
        one_low = 1'b0;
        c_idx   = 2'd0;
        case (cs)
            4'b1110: begin one_low = 1'b1; c_idx = 2'd0; end
            4'b1101: begin one_low = 1'b1; c_idx = 2'd1; end
            4'b1011: begin one_low = 1'b1; c_idx = 2'd2; end
            4'b0111: begin one_low = 1'b1; c_idx = 2'd3; end
            default: begin one_low = 1'b0; c_idx = 2'd0; end
        endcase
    end

    // Scan / press-debounce / held / release-debounce state machine.
    always_comb begin
        state_d   = state_q;
        row_idx_d = row_idx_q;
        col_idx_d = col_idx_q;
        dwell_d   = dwell_q;
        deb_d     = deb_q;
        accept    = 1'b0;
        case (state_q)
            ST_SCAN: begin
                dwell_d = dwell_q + 1'b1;
                if (dwell_q == DWELL_LAST) begin
                    if (one_low) begin
                        state_d   = ST_PDEB;
                        col_idx_d = c_idx;
                        deb_d     = '0;
                    end else begin
                        row_idx_d = row_idx_q + 2'd1;
                    end
                end
            end
            ST_PDEB: begin
                if (cs == onehot_low(col_idx_q)) begin
                    if (deb_q == DEB_LAST) begin
                        accept  = 1'b1;
                        state_d = ST_HELD;
                    end else begin
                        deb_d = deb_q + 1'b1;
                    end
                end else begin
                    state_d   = ST_SCAN;
                    row_idx_d = row_idx_q + 2'd1;
                    dwell_d   = '0;
                end
            end
            ST_HELD: begin
                if (cs == 4'b1111) begin
                    state_d = ST_RDEB;
                    deb_d   = '0;
                end
            end
            ST_RDEB: begin
                if (cs != 4'b1111) begin
                    state_d = ST_HELD;
                end else if (deb_q == DEB_LAST) begin
                    state_d   = ST_SCAN;
                    row_idx_d = row_idx_q + 2'd1;
                    dwell_d   = '0;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_SCAN;
            end
        endcase
    end

    // Output word update; flush beats a coincident accept for data only.
    always_comb begin
        map_code    = key_lookup(row_idx_q, col_idx_q);
        key_valid_d = accept;
        key_code_d  = accept ? map_code : key_code_q;
        if (flush) begin
            data_d = '0;
        end else if (accept) begin
            data_d = {data_q[27:0], map_code};
        end else begin
            data_d = data_q;
        end
    end

    // State and output registers, cleared asynchronously by clr.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= ST_SCAN;
            row_idx_q   <= 2'd0;
            col_idx_q   <= 2'd0;
            dwell_q     <= '0;
            deb_q       <= '0;
            data_q      <= '0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_idx_q   <= row_idx_d;
            col_idx_q   <= col_idx_d;
            dwell_q     <= dwell_d;
            deb_q       <= deb_d;
            data_q      <= data_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign row       = onehot_low(row_idx_q);
    assign data      = data_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_hex_entry.sv
// tb/tb_keypad_hex_entry.sv - directed vector bench for keypad_hex_entry
module tb_keypad_hex_entry;

    logic        clk = 1'b0;
    logic        clr;
    logic        flush;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [31:0] data;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [15:0] keys_down;

    int n_vec  = 0;
    int n_err  = 0;
    int cycle  = 0;
    int pulses = 0;
    int last_pulse = 0;

    typedef struct {
        int          key;
        logic [3:0]  code;
        logic [31:0] word;
    } vec_t;

    vec_t vecs [14];

    always #5 clk = ~clk;

    keypad_hex_entry #(
        .SCAN_BITS       (2),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .flush     (flush),
        .col       (col),
        .row       (row),
        .data      (data),
        .key_code  (key_code),
        .key_valid (key_valid)
    );

    // Keypad matrix: a pressed key shorts its column low while its row is driven low.
    always_comb begin
        col = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row[r] && keys_down[r*4+c]) col[c] = 1'b0;
            end
        end
    end

    // Pulse monitor.
    always @(negedge clk) begin
        cycle = cycle + 1;
        if (key_valid) begin
            pulses = pulses + 1;
            last_pulse = cycle;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_pulse(input int bound, output bit got);
        got = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (key_valid) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_row(input logic [3:0] r, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (row == r) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, 32'(ok), 32'd1);
    endtask

    task automatic press_and_check(input int k, input logic [3:0] ec, input logic [31:0] ed,
                                   input string name);
        int p0;
        bit got;
        p0 = pulses;
        keys_down[k] = 1'b1;
        wait_pulse(100, got);
        check({name, "_seen"}, 32'(got), 32'd1);
        check({name, "_code"}, 32'(key_code), 32'(ec));
        check({name, "_data"}, data, ed);
        repeat (20) @(negedge clk);
        keys_down[k] = 1'b0;
        repeat (30) @(negedge clk);
        check({name, "_pulses"}, 32'(pulses - p0), 32'd1);
    endtask

    initial begin
        int  p0;
        int  hold_start;
        bit  got;

        vecs[0]  = '{6,  4'h6, 32'h0000_0006};
        vecs[1]  = '{3,  4'hA, 32'h0000_006A};
        vecs[2]  = '{-1, 4'hA, 32'h0000_0000};
        vecs[3]  = '{0,  4'h1, 32'h0000_0001};
        vecs[4]  = '{1,  4'h2, 32'h0000_0012};
        vecs[5]  = '{2,  4'h3, 32'h0000_0123};
        vecs[6]  = '{4,  4'h4, 32'h0000_1234};
        vecs[7]  = '{5,  4'h5, 32'h0001_2345};
        vecs[8]  = '{6,  4'h6, 32'h0012_3456};
        vecs[9]  = '{8,  4'h7, 32'h0123_4567};
        vecs[10] = '{9,  4'h8, 32'h1234_5678};
        vecs[11] = '{10, 4'h9, 32'h2345_6789};
        vecs[12] = '{12, 4'h0, 32'h3456_7890};
        vecs[13] = '{15, 4'hD, 32'h4567_890D};

        clr       = 1'b1;
        flush     = 1'b0;
        keys_down = '0;
        #1;
        check("reset_row",   32'(row),       32'hE);
        check("reset_data",  data,           32'h0);
        check("reset_code",  32'(key_code),  32'h0);
        check("reset_valid", 32'(key_valid), 32'h0);
        repeat (2) @(negedge clk);
        clr = 1'b0;
        repeat (3) @(negedge clk);

        // Entry sequence: single keys, flush, nine-digit overflow, row-3 keys.
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].key < 0) begin
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
                @(negedge clk);
                check($sformatf("vec%0d_flush_data", i), data, vecs[i].word);
                check($sformatf("vec%0d_flush_code", i), 32'(key_code), 32'(vecs[i].code));
            end else begin
                press_and_check(vecs[i].key, vecs[i].code, vecs[i].word, $sformatf("vec%0d", i));
            end
        end

        // Two keys in the same row are ignored.
        p0 = pulses;
        keys_down[0] = 1'b1;
        keys_down[1] = 1'b1;
        repeat (80) @(negedge clk);
        keys_down = '0;
        repeat (30) @(negedge clk);
        check("multi_pulses", 32'(pulses - p0), 32'd0);
        check("multi_data",   data, 32'h4567_890D);

        // Press bounce on key 4 (c0): toggle every 3 cycles, then hold.
        p0 = pulses;
        hold_start = 0;
        for (int i = 0; i < 20; i++) begin
            if (i % 3 == 0) begin
                keys_down[4] = ~keys_down[4];
                hold_start = cycle;
            end
            @(negedge clk);
        end
        wait_pulse(120, got);
        check("bounce_seen", 32'(got), 32'd1);
        check("bounce_code", 32'(key_code), 32'h4);
        check("bounce_data", data, 32'h5678_90D4);
        repeat (20) @(negedge clk);
        check("bounce_delay", 32'((last_pulse - hold_start) >= 8), 32'd1);
        keys_down[4] = 1'b0;
        repeat (30) @(negedge clk);
        check("bounce_pulses", 32'(pulses - p0), 32'd1);

        // Held key 5 with 2-cycle release glitches: still one event.
        p0 = pulses;
        keys_down[5] = 1'b1;
        wait_pulse(100, got);
        check("held_seen", 32'(got), 32'd1);
        check("held_data", data, 32'h6789_0D45);
        for (int i = 0; i < 100; i++) begin
            keys_down[5] = !((i % 7) == 3 || (i % 7) == 4);
            @(negedge clk);
        end
        keys_down[5] = 1'b0;
        repeat (30) @(negedge clk);
        check("held_pulses", 32'(pulses - p0), 32'd1);

        // clr asserted in the middle of press debounce, key still held afterwards.
        p0 = pulses;
        wait_row(4'b1110, "rst_wait_r0");
        keys_down[6] = 1'b1;
        wait_row(4'b1101, "rst_wait_r1");
        repeat (6) @(posedge clk);
        #2;
        clr = 1'b1;
        #1;
        check("clr_row",    32'(row),       32'hE);
        check("clr_data",   data,           32'h0);
        check("clr_code",   32'(key_code),  32'h0);
        check("clr_valid",  32'(key_valid), 32'h0);
        check("clr_nopulse", 32'(pulses - p0), 32'd0);
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        check("clr_restart_row", 32'(row), 32'hE);
        wait_pulse(100, got);
        check("clr_redetect_seen", 32'(got), 32'd1);
        check("clr_redetect_code", 32'(key_code), 32'h6);
        check("clr_redetect_data", data, 32'h0000_0006);
        keys_down[6] = 1'b0;
        repeat (30) @(negedge clk);
        check("clr_pulses", 32'(pulses - p0), 32'd1);

        // flush in the exact cycle key F is accepted.
        wait_row(4'b1110, "flush_wait_r0");
        keys_down[13] = 1'b1;
        wait_row(4'b0111, "flush_wait_r3");
        repeat (11) @(posedge clk);
        #1;
        check("flush_pre_valid", 32'(key_valid), 32'h0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_acc_data",  data,           32'h0);
        check("flush_acc_code",  32'(key_code),  32'hF);
        check("flush_acc_valid", 32'(key_valid), 32'h1);
        @(posedge clk);
        #1;
        check("flush_post_valid", 32'(key_valid), 32'h0);
        check("flush_post_data",  data,           32'h0);
        keys_down[13] = 1'b0;
        repeat (30) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
